// File: rtl/riscv_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: width, funct3 codes, FSM states.
package riscv_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the unsigned datapath on a 2*XLEN accumulator.
//   multiply: acc = {hi, multiplier}; add multiplicand into hi when lsb set, shift right.
//   divide:   acc = {remainder, dividend/quotient}; shift left, restoring subtract.
import riscv_muldiv_pkg::*;

module muldiv_iter_step (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   partial;
  logic            ge;
  logic [XLEN-1:0] rem_new;

  // select shift-add or shift-subtract result for this step
  always_comb begin
    sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
    partial = acc_in[2*XLEN-1:XLEN-1];
    ge      = partial >= {1'b0, operand};
    // remainder always < divisor, so the difference fits in XLEN bits when ge
    rem_new = partial[XLEN-1:0] - operand;
    if (is_div) begin
      if (ge) acc_out = {rem_new, acc_in[XLEN-2:0], 1'b1};
      else    acc_out = {acc_in[2*XLEN-2:0], 1'b0};
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Signed ops run on magnitudes with the result sign fixed on the last iteration.
// Divide-by-zero and signed overflow finish in one cycle.
// Optional: define MULDIV_FAST_MUL_EN for single-cycle multiplies.
import riscv_muldiv_pkg::*;

module riscv_muldiv_unit (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] op_a_in,
  input  logic [XLEN-1:0] op_b_in,
  input  logic            flush_in,
  output logic            stall_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        f3;
  logic              neg;

  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              div0, ovf;
  logic [XLEN-1:0]   special_res;
  logic [2*XLEN-1:0] step_out;
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   quo, rmd, fix_res;

  // operand decode for the op being issued
  always_comb begin
    a_signed    = (funct3_in == MULH) || (funct3_in == MULHSU) ||
                  (funct3_in == DIV)  || (funct3_in == REM);
    b_signed    = (funct3_in == MULH) || (funct3_in == DIV) || (funct3_in == REM);
    sa          = a_signed & op_a_in[XLEN-1];
    sb          = b_signed & op_b_in[XLEN-1];
    mag_a       = sa ? -op_a_in : op_a_in;
    mag_b       = sb ? -op_b_in : op_b_in;
    div0        = funct3_in[2] && (op_b_in == '0);
    ovf         = ((funct3_in == DIV) || (funct3_in == REM)) &&
                  (op_a_in == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_in == '1);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div0)           special_res = funct3_in[1] ? op_a_in : '1;
    else if (funct3_in[1]) special_res = '0;
    else                special_res = {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] fast_prod;
  logic [XLEN-1:0]          fast_res;

  // 33x33 signed product; the extra bit encodes signed/unsigned per operand
  always_comb begin
    fast_prod = $signed({sa, op_a_in}) * $signed({sb, op_b_in});
    fast_res  = (funct3_in == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  muldiv_iter_step u_step (
    .is_div  (f3[2]),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (step_out)
  );

  // sign fix and result select on the final iteration output
  always_comb begin
    mul_full = neg ? -step_out : step_out;
    quo      = neg ? -step_out[XLEN-1:0] : step_out[XLEN-1:0];
    rmd      = neg ? -step_out[2*XLEN-1:XLEN] : step_out[2*XLEN-1:XLEN];
    case (f3)
      MUL:               fix_res = mul_full[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = mul_full[2*XLEN-1:XLEN];
      DIV, DIVU:         fix_res = quo;
      default:           fix_res = rmd;
    endcase
  end

  // stall the issuing cycle and every busy cycle
  assign stall_out = ((state == IDLE) && start_in && !flush_in) || (state == BUSY);

  // control FSM with iteration state and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      f3         <= '0;
      neg        <= 1'b0;
      result_out <= '0;
      done_out   <= 1'b0;
    end else if (flush_in) begin
      state    <= IDLE;
      done_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_out <= 1'b0;
          if (start_in) begin
            f3 <= funct3_in;
            if (div0 || ovf) begin
              result_out <= special_res;
              done_out   <= 1'b1;
              state      <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!funct3_in[2]) begin
              result_out <= fast_res;
              done_out   <= 1'b1;
              state      <= DONE;
`endif
            end else begin
              // multiplier / dividend lives in the low half, the other operand in opnd
              acc   <= {{XLEN{1'b0}}, funct3_in[2] ? mag_a : mag_b};
              opnd  <= funct3_in[2] ? mag_b : mag_a;
              neg   <= (funct3_in == REM) ? sa : (sa ^ sb);
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_out;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            result_out <= fix_res;
            done_out   <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          done_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Scoreboard bench for riscv_muldiv_unit: directed RV32M vectors, expected
// result and completion cycle queued at issue, checked by a done_out monitor.
import riscv_muldiv_pkg::*;

module tb_riscv_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  localparam int DL = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic [2:0]  funct3_in;
  logic [31:0] op_a_in;
  logic [31:0] op_b_in;
  logic        flush_in;
  logic        stall_out;
  logic        done_out;
  logic [31:0] result_out;

  riscv_muldiv_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .funct3_in  (funct3_in),
    .op_a_in    (op_a_in),
    .op_b_in    (op_b_in),
    .flush_in   (flush_in),
    .stall_out  (stall_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: every done_out must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h expected=no_done at cycle %0d", result_out, cyc);
      end else begin
        e = sb.pop_front();
        chk(e.name, result_out, e.res);
        chk({e.name, "_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    int n;
    bit stall_bad;
    @(negedge clk);
    start_in  = 1'b1;
    funct3_in = f;
    op_a_in   = a;
    op_b_in   = b;
    sb.push_back('{name: name, res: res, at: cyc + lat});
    #1 stall_bad = (stall_out !== 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (done_out !== 1'b1 && stall_out !== 1'b1) stall_bad = 1'b1;
      if (done_out === 1'b1 && stall_out !== 1'b0) stall_bad = 1'b1;
    end while (done_out !== 1'b1 && n < 40);
    start_in = 1'b0;
    if (done_out !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done within 40 cycles", name);
    end
    chk({name, "_stall"}, {31'b0, stall_bad}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_in = 1'b0; funct3_in = 3'b0;
    op_a_in = '0; op_b_in = '0; flush_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", result_out, 32'd0);
    chk("rst_done", {31'b0, done_out}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    reset = 1'b0;

    run_op("mul_7x6",      MUL,    32'd7,        32'd6,        32'd42,       ML);
    run_op("mulh_m1m1",    MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML);
    run_op("mulhu_m1m1",   MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML);
    run_op("mulhsu_m1x2",  MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, ML);
    run_op("mul_lo_m1m1",  MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, ML);
    run_op("mulh_min_min", MULH,   32'h80000000, 32'h80000000, 32'h40000000, ML);
    run_op("div_ovf",      DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",      REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("divu_by0",     DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_by0",     REMU,   32'd100,      32'd0,        32'd100,      1);
    run_op("div_by0",      DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",      REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
    run_op("div_m7_2",     DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DL);
    run_op("rem_m7_2",     REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DL);
    run_op("rem_7_m2",     REM,    32'd7,        32'hFFFFFFFE, 32'd1,        DL);
    run_op("div_min_2",    DIV,    32'h80000000, 32'd2,        32'hC0000000, DL);
    run_op("divu_min_m1",  DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        DL);
    run_op("remu_m1_16",   REMU,   32'hFFFFFFFF, 32'd16,       32'd15,       DL);
    run_op("divu_big_2",   DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, DL);
    @(negedge clk);
    chk("result_hold", result_out, 32'h7FFFFFFC);

    // flush mid-divide: no completion, unit idle, next op accepted
    @(negedge clk);
    start_in = 1'b1; funct3_in = DIV; op_a_in = 32'd100; op_b_in = 32'd7;
    repeat (10) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0; start_in = 1'b0;
    #1;
    chk("flush_stall", {31'b0, stall_out}, 32'd0);
    chk("flush_done", {31'b0, done_out}, 32'd0);
    chk("flush_result_kept", result_out, 32'h7FFFFFFC);
    run_op("mul_after_flush", MUL, 32'd3, 32'd5, 32'd15, ML);

    // reset during a multiply
    @(negedge clk);
    start_in = 1'b1; funct3_in = MUL; op_a_in = 32'd9; op_b_in = 32'd9;
    repeat (5) @(negedge clk);
    reset = 1'b1; start_in = 1'b0;
    @(negedge clk);
    chk("midrst_result", result_out, 32'd0);
    chk("midrst_done", {31'b0, done_out}, 32'd0);
    chk("midrst_stall", {31'b0, stall_out}, 32'd0);
    reset = 1'b0;
    run_op("mul_after_rst", MUL, 32'd7, 32'd6, 32'd42, ML);
    repeat (40) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
